// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core sharing one ALU and one
// ready-handshaked memory port between instruction fetch and data access.
module mips_multicycle_core #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              instr_retired,
    output logic              halted,
    output logic [3:0]        state_out
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, RWB, ADDIWB, MEMADR, MEMRD, MEMWB, MEMWR, BRJ, TRAP
    } state_t;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
    state_t      state;
    logic [31:0] regs [32];
    logic [31:0] ir, mdr, a, b, alu_out, pc_next, alu_res, ea, imm_s;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign imm_s = {{16{ir[15]}}, ir[15:0]};
    assign ea    = a + imm_s;
    always_comb begin
        alu_res = (op != OP_R)    ? a + imm_s :
                  (funct == 6'h20) ? a + b :
                  (funct == 6'h22) ? a - b :
                  (funct == 6'h24) ? a & b :
                  (funct == 6'h25) ? a | b :
                  (funct == 6'h2A) ? {31'b0, $signed(a) < $signed(b)} : 32'h0;
    end
    // The port is gated by rst so nothing is requested while reset is held.
    assign mem_req   = rst && (state == FETCH || state == MEMRD || state == MEMWR);
    assign mem_we    = mem_req && state == MEMWR;
    assign mem_addr  = mem_req ? {(state == FETCH ? pc_out[ADDR_W-1:2] : alu_out[ADDR_W-1:2]), 2'b00}
                               : '0;
    assign mem_wdata = b;
    assign halted    = state == TRAP;
    assign state_out = state;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH;
            pc_out        <= RESET_PC;
            pc_next       <= '0;
            ir            <= '0;
            mdr           <= '0;
            a             <= '0;
            b             <= '0;
            alu_out       <= '0;
            instr_retired <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            instr_retired <= 1'b0;
            case (state)
                FETCH: if (mem_ready) begin
                    ir      <= mem_rdata;
                    pc_next <= pc_out + 32'd4;
                    state   <= DECODE;
                end
                DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= pc_next + {imm_s[29:0], 2'b00};
                    if (op == OP_R || op == OP_ADDI) state <= EXEC;
                    else if (op == OP_LW || op == OP_SW) state <= MEMADR;
                    else if (op == OP_BEQ || op == OP_J) state <= BRJ;
                    else if (TRAP_EN) state <= TRAP;
                    else begin
                        pc_out        <= pc_next;
                        instr_retired <= 1'b1;
                        state         <= FETCH;
                    end
                end
                EXEC: begin
                    alu_out <= alu_res;
                    state   <= (op == OP_R) ? RWB : ADDIWB;
                end
                RWB, ADDIWB, MEMWB: begin
                    if (state == RWB && rd != 5'd0) regs[rd] <= alu_out;
                    if (state == ADDIWB && rt != 5'd0) regs[rt] <= alu_out;
                    if (state == MEMWB && rt != 5'd0) regs[rt] <= mdr;
                    pc_out        <= pc_next;
                    instr_retired <= 1'b1;
                    state         <= FETCH;
                end
                MEMADR: begin
                    alu_out <= ea;
                    if (ea[1:0] == 2'b00) state <= (op == OP_LW) ? MEMRD : MEMWR;
                    else if (TRAP_EN) state <= TRAP;
                    else begin
                        pc_out        <= pc_next;
                        instr_retired <= 1'b1;
                        state         <= FETCH;
                    end
                end
                MEMRD: if (mem_ready) begin
                    mdr   <= mem_rdata;
                    state <= MEMWB;
                end
                MEMWR: if (mem_ready) begin
                    pc_out        <= pc_next;
                    instr_retired <= 1'b1;
                    state         <= FETCH;
                end
                BRJ: begin
                    pc_out        <= (op == OP_J) ? {pc_next[31:28], ir[25:0], 2'b00}
                                                  : (a == b) ? alu_out : pc_next;
                    instr_retired <= 1'b1;
                    state         <= FETCH;
                end
                default: state <= state;
            endcase
        end
    end
endmodule
